// File: rtl/vae_display_pkg.sv
// Shared constants and types for the vae display stage.
//   GRID/DW/FRAC     : image geometry and sample format (Q.FRAC signed samples)
//   CELL_SHIFT       : log2 of the on-screen cell size
//   X_OFF/Y_OFF      : top-left corner of the grid in raster coordinates
//   BORDER           : colour shown outside the grid
package vae_display_pkg;

  localparam int unsigned GRID       = 14;
  localparam int unsigned DW         = 10;
  localparam int unsigned FRAC       = 8;
  localparam int unsigned CELL_SHIFT = 5;
  localparam int unsigned X_OFF      = 96;
  localparam int unsigned Y_OFF      = 16;
  localparam int unsigned NCELLS     = GRID * GRID;
  localparam logic [11:0] BORDER     = 12'h000;

  typedef logic signed [DW-1:0] sample_t;
  typedef sample_t [0:NCELLS-1] image_t;
  typedef logic [11:0]          rgb444_t;

endpackage

// File: rtl/gray_quantizer.sv
// Combinational clamp of a signed fixed-point sample to a 4-bit grey level.
//   sample_i : signed sample, 1.0 == 2^FRAC
//   gray_o   : 0 for negative, 15 for >= 1.0, else the top 4 fraction bits
module gray_quantizer #(
  parameter int unsigned DW   = 10,
  parameter int unsigned FRAC = 8
) (
  input  logic signed [DW-1:0] sample_i,
  output logic [3:0]           gray_o
);

  always_comb begin
    gray_o = sample_i[FRAC-1:FRAC-4];
    if (sample_i[DW-1]) begin
      gray_o = 4'h0;
    end else if (|sample_i[DW-2:FRAC]) begin
      // Any integer bit set on a non-negative sample means >= 1.0.
      gray_o = 4'hf;
    end
  end

endmodule

// File: rtl/vae_frame_display.sv
// Double-buffered display stage for the vae decoder output.
//   clk, rst            : pixel clock, synchronous active-high reset
//   finish, image_in    : rising edge of finish captures image_in into staging
//   h_cnt, v_cnt, valid : raster position from the VGA controller
//   pixel, pixel_valid  : RGB444 pixel and valid, 2 cycles after the raster inputs
//   frame_ready         : set once the first captured image has been promoted
// Staging is promoted to display only at frame start (0,0), so frames never tear.
module vae_frame_display
  import vae_display_pkg::*;
#(
  parameter int unsigned GRID       = vae_display_pkg::GRID,
  parameter int unsigned DW         = vae_display_pkg::DW,
  parameter int unsigned FRAC       = vae_display_pkg::FRAC,
  parameter int unsigned CELL_SHIFT = vae_display_pkg::CELL_SHIFT,
  parameter int unsigned X_OFF      = vae_display_pkg::X_OFF,
  parameter int unsigned Y_OFF      = vae_display_pkg::Y_OFF,
  parameter logic [11:0] BORDER     = vae_display_pkg::BORDER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finish,
  input  image_t      image_in,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  output rgb444_t     pixel,
  output logic        pixel_valid,
  output logic        frame_ready
);

  localparam logic [9:0] XStart = 10'(X_OFF);
  localparam logic [9:0] YStart = 10'(Y_OFF);
  localparam logic [9:0] XEnd   = 10'(X_OFF + (GRID << CELL_SHIFT));
  localparam logic [9:0] YEnd   = 10'(Y_OFF + (GRID << CELL_SHIFT));

  // Buffer control
  image_t staging_q, staging_d;
  image_t display_q, display_d;
  logic   pending_q, pending_d;
  logic   ready_q, ready_d;
  logic   finish_q;
  logic   capture, frame_start;

  assign capture     = finish & ~finish_q;
  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_comb begin
    staging_d = staging_q;
    display_d = display_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    if (frame_start && pending_q) begin
      display_d = staging_q;
      pending_d = 1'b0;
      ready_d   = 1'b1;
    end
    // Capture comes last so a coincident capture leaves pending set.
    if (capture) begin
      staging_d = image_in;
      pending_d = 1'b1;
    end
  end

  // Stage 1: raster position to cell index
  logic [9:0] h_rel, v_rel;
  logic [3:0] col, row;
  logic       in_grid_d, in_grid_q;
  logic [7:0] idx_d, idx_q;
  logic       valid1_q;

  always_comb begin
    h_rel     = h_cnt - XStart;
    v_rel     = v_cnt - YStart;
    col       = 4'(h_rel >> CELL_SHIFT);
    row       = 4'(v_rel >> CELL_SHIFT);
    in_grid_d = (h_cnt >= XStart) && (h_cnt < XEnd) && (v_cnt >= YStart) && (v_cnt < YEnd);
    idx_d     = 8'd0;
    if (in_grid_d) begin
      idx_d = 8'({4'd0, row} * 8'(GRID)) + {4'd0, col};
    end
  end

  // Stage 2: sample lookup and quantisation
  logic [3:0] gray;
  rgb444_t    pixel_d;

  gray_quantizer #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_quant (
    .sample_i (display_q[idx_q]),
    .gray_o   (gray)
  );

  always_comb begin
    pixel_d = 12'h000;
    if (valid1_q) begin
      pixel_d = in_grid_q ? {gray, gray, gray} : BORDER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_q    <= 1'b0;
      staging_q   <= '0;
      display_q   <= '0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b0;
      in_grid_q   <= 1'b0;
      idx_q       <= 8'd0;
      valid1_q    <= 1'b0;
      pixel       <= 12'h000;
      pixel_valid <= 1'b0;
    end else begin
      finish_q    <= finish;
      staging_q   <= staging_d;
      display_q   <= display_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      in_grid_q   <= in_grid_d;
      idx_q       <= idx_d;
      valid1_q    <= valid;
      pixel       <= pixel_d;
      pixel_valid <= valid1_q;
    end
  end

  assign frame_ready = ready_q;

endmodule

// File: tb/tb_vae_frame_display.sv
// Directed bench for vae_frame_display: table-driven pixel checks plus
// hand-written capture/promotion/reset sequences.
module tb_vae_frame_display;
  import vae_display_pkg::*;

  localparam rgb444_t Brd = 12'h5A3;

  logic       clk = 1'b0;
  logic       rst;
  logic       finish;
  image_t     img;
  logic [9:0] h, v;
  logic       valid;
  rgb444_t    pixel;
  logic       pixel_valid;
  logic       frame_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vae_frame_display #(
    .BORDER (Brd)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .finish      (finish),
    .image_in    (img),
    .h_cnt       (h),
    .v_cnt       (v),
    .valid       (valid),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .frame_ready (frame_ready)
  );

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       vl;
    rgb444_t    exp;
    string      name;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h = 10'd639;
    v = 10'd479;
    valid = 1'b0;
  endtask

  // Present one raster position, then check the pixel 2 edges later.
  task automatic check_pix(input string name, input logic [9:0] hh, input logic [9:0] vv,
                           input logic vl, input rgb444_t exp);
    h = hh;
    v = vv;
    valid = vl;
    tick();
    idle();
    tick();
    chk(name, 32'(pixel), 32'(exp));
    chk({name, " pv"}, 32'(pixel_valid), 32'(vl));
  endtask

  task automatic run_table();
    foreach (tab[i]) check_pix(tab[i].name, tab[i].h, tab[i].v, tab[i].vl, tab[i].exp);
    tab.delete();
  endtask

  task automatic frame_start();
    h = 10'd0;
    v = 10'd0;
    valid = 1'b0;
    tick();
    idle();
  endtask

  task automatic fill(input sample_t s);
    for (int i = 0; i < int'(NCELLS); i++) img[i] = s;
  endtask

  // Low cycle then rising edge; finish is left high.
  task automatic capture();
    finish = 1'b0;
    tick();
    finish = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    finish = 1'b0;
    fill(10'sd0);
    idle();
    repeat (3) tick();
    chk("reset pixel", 32'(pixel), 32'h0);
    chk("reset pixel_valid", 32'(pixel_valid), 32'h0);
    chk("reset frame_ready", 32'(frame_ready), 32'h0);
    rst = 1'b0;
    tick();

    // No image yet: grid is black, border elsewhere.
    tab.push_back('{10'd96,  10'd16,  1'b1, 12'h000, "empty grid tl"});
    tab.push_back('{10'd300, 10'd200, 1'b1, 12'h000, "empty grid mid"});
    tab.push_back('{10'd543, 10'd463, 1'b1, 12'h000, "empty grid br"});
    tab.push_back('{10'd0,   10'd0,   1'b1, Brd,     "origin border"});
    tab.push_back('{10'd95,  10'd16,  1'b1, Brd,     "left of grid"});
    tab.push_back('{10'd96,  10'd15,  1'b1, Brd,     "above grid"});
    tab.push_back('{10'd100, 10'd100, 1'b0, 12'h000, "invalid blank"});
    run_table();
    chk("no image frame_ready", 32'(frame_ready), 32'h0);

    // Mid-frame capture of all 128 shows only from the next frame.
    fill(10'sd128);
    capture();
    check_pix("same frame unchanged", 10'd96, 10'd16, 1'b1, 12'h000);
    chk("pre-promote frame_ready", 32'(frame_ready), 32'h0);
    frame_start();
    check_pix("128 shown", 10'd96, 10'd16, 1'b1, 12'h888);
    chk("frame_ready set", 32'(frame_ready), 32'h1);

    // Quantiser corner values in row 0.
    fill(10'sd0);
    img[0] = -10'sd4;
    img[1] = 10'sd255;
    img[2] = 10'sd256;
    img[3] = 10'sd300;
    img[4] = 10'sd16;
    capture();
    frame_start();
    tab.push_back('{10'd101, 10'd20, 1'b1, 12'h000, "q -4"});
    tab.push_back('{10'd133, 10'd20, 1'b1, 12'hfff, "q 255"});
    tab.push_back('{10'd165, 10'd20, 1'b1, 12'hfff, "q 256"});
    tab.push_back('{10'd197, 10'd20, 1'b1, 12'hfff, "q 300"});
    tab.push_back('{10'd229, 10'd20, 1'b1, 12'h111, "q 16"});
    run_table();

    // Last cell and the grid's far edges.
    fill(10'sd0);
    img[195] = 10'sd200;
    capture();
    frame_start();
    tab.push_back('{10'd543, 10'd463, 1'b1, 12'hccc, "cell195 br"});
    tab.push_back('{10'd512, 10'd432, 1'b1, 12'hccc, "cell195 tl"});
    tab.push_back('{10'd511, 10'd432, 1'b1, 12'h000, "cell194"});
    tab.push_back('{10'd544, 10'd463, 1'b1, Brd,     "right edge"});
    tab.push_back('{10'd543, 10'd464, 1'b1, Brd,     "bottom edge"});
    run_table();

    // Two captures in one frame: last one wins.
    fill(10'sd32);
    capture();
    fill(10'sd64);
    capture();
    frame_start();
    check_pix("last capture wins a", 10'd96, 10'd16, 1'b1, 12'h444);
    check_pix("last capture wins b", 10'd300, 10'd300, 1'b1, 12'h444);

    // Pending 32, then a rising edge with 16 exactly at (0,0).
    fill(10'sd32);
    capture();
    finish = 1'b0;
    tick();
    fill(10'sd16);
    finish = 1'b1;
    h = 10'd0;
    v = 10'd0;
    valid = 1'b0;
    tick();
    idle();
    check_pix("coincident shows prior", 10'd96, 10'd16, 1'b1, 12'h222);
    frame_start();
    check_pix("coincident next frame", 10'd96, 10'd16, 1'b1, 12'h111);

    // finish held high must not re-capture.
    fill(10'sd128);
    tick();
    frame_start();
    check_pix("held finish no recapture", 10'd96, 10'd16, 1'b1, 12'h111);

    // Reset mid-frame with a valid in-grid pixel in flight.
    finish = 1'b0;
    tick();
    h = 10'd96;
    v = 10'd16;
    valid = 1'b1;
    rst = 1'b1;
    tick();
    chk("mid reset pixel", 32'(pixel), 32'h0);
    chk("mid reset pixel_valid", 32'(pixel_valid), 32'h0);
    chk("mid reset frame_ready", 32'(frame_ready), 32'h0);
    h = 10'd10;
    v = 10'd10;
    valid = 1'b1;
    rst = 1'b0;
    tick();
    idle();
    chk("post reset cycle1 pixel", 32'(pixel), 32'h0);
    tick();
    chk("post reset cycle2 pixel", 32'(pixel), 32'(Brd));
    check_pix("post reset black", 10'd96, 10'd16, 1'b1, 12'h000);
    frame_start();
    check_pix("no pending keeps black", 10'd96, 10'd16, 1'b1, 12'h000);
    chk("no pending frame_ready", 32'(frame_ready), 32'h0);
    fill(10'sd128);
    capture();
    frame_start();
    check_pix("recover 128", 10'd96, 10'd16, 1'b1, 12'h888);
    chk("recover frame_ready", 32'(frame_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
